// File: rtl/octa_alu_pkg.sv
// Shared definitions for the 8-bit ALU and the 16-bit operation sequencer:
// ALU control codes, sequencer op codes, FSM states and per-op step counts.
package octa_alu_pkg;

   localparam int ALU_W = 8;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_LOGIC = 3'b001;
   localparam logic [2:0] ALU_SLTU  = 3'b010;
   localparam logic [2:0] ALU_SHIFT = 3'b011;
   localparam logic [2:0] ALU_SRA   = 3'b100;

   localparam logic [2:0] OP_ADD16  = 3'b000;
   localparam logic [2:0] OP_SUB16  = 3'b001;
   localparam logic [2:0] OP_NAND16 = 3'b010;
   localparam logic [2:0] OP_NOR16  = 3'b011;
   localparam logic [2:0] OP_SLTU16 = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_DONE = 2'b10
   } seq_state_e;

   // Where the ALU result of the current step is written.
   typedef enum logic [2:0] {
      DEST_NONE  = 3'd0,
      DEST_R_LO  = 3'd1,
      DEST_CARRY = 3'd2,
      DEST_T     = 3'd3,
      DEST_R_HI  = 3'd4,
      DEST_LT    = 3'd5,
      DEST_GT    = 3'd6,
      DEST_LL    = 3'd7
   } dest_e;

   function automatic logic op_legal(input logic [2:0] op);
      logic legal_v;
      case (op)
         OP_ADD16, OP_SUB16, OP_NAND16, OP_NOR16, OP_SLTU16: legal_v = 1'b1;
         default:                                             legal_v = 1'b0;
      endcase
      return legal_v;
   endfunction

   // Index of the final micro-op step for each op.
   function automatic logic [1:0] op_last_step(input logic [2:0] op);
      logic [1:0] last_v;
      case (op)
         OP_ADD16, OP_SUB16:  last_v = 2'd3;
         OP_NAND16, OP_NOR16: last_v = 2'd1;
         OP_SLTU16:           last_v = 2'd2;
         default:             last_v = 2'd0;
      endcase
      return last_v;
   endfunction

endpackage

// File: rtl/alu.sv
// Shared combinational 8-bit ALU: add/sub, NAND/NOR, unsigned compare and shifts.
module alu
   import octa_alu_pkg::*;
#(
   parameter int DATA_W = ALU_W
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [2:0]        ctrl,
   input  logic              flag,
   output logic [DATA_W-1:0] out
);

   // Operation select; flag picks subtract, NAND vs NOR, or shift direction.
   always_comb begin
      out = {DATA_W{1'b0}};
      case (ctrl)
         ALU_ADD: begin
            if (flag) out = a - b;
            else      out = a + b;
         end
         ALU_LOGIC: begin
            if (flag) out = ~(a & b);
            else      out = ~(a | b);
         end
         ALU_SLTU:  out = {{(DATA_W-1){1'b0}}, (a < b)};
         ALU_SHIFT: begin
            if (flag) out = a >> b;
            else      out = a << b;
         end
         ALU_SRA:   out = DATA_W'($signed(a) >>> b);
         default:   out = {DATA_W{1'b0}};
      endcase
   end

endmodule

// File: rtl/alu_seq16_ucode.sv
// Micro-op table: maps (op, step, latched operands, temporaries) onto the ALU
// inputs for the current cycle and names the register that captures the result.
module alu_seq16_ucode
   import octa_alu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic                exec,
   input  logic [2:0]          op,
   input  logic [1:0]          step,
   input  logic [2*DATA_W-1:0] a,
   input  logic [2*DATA_W-1:0] b,
   input  logic [DATA_W-1:0]   r_lo,
   input  logic [DATA_W-1:0]   t,
   input  logic                carry,
   output logic [DATA_W-1:0]   alu_a,
   output logic [DATA_W-1:0]   alu_b,
   output logic [2:0]          alu_ctrl,
   output logic                alu_flag,
   output dest_e               dest
);

   logic [DATA_W-1:0] a_lo_s, a_hi_s, b_lo_s, b_hi_s, carry_s;

   assign a_lo_s  = a[DATA_W-1:0];
   assign a_hi_s  = a[2*DATA_W-1:DATA_W];
   assign b_lo_s  = b[DATA_W-1:0];
   assign b_hi_s  = b[2*DATA_W-1:DATA_W];
   assign carry_s = {{(DATA_W-1){1'b0}}, carry};

   // Per-step ALU drive; outside EXEC the ALU sees all-zero idle inputs.
   always_comb begin
      alu_a    = {DATA_W{1'b0}};
      alu_b    = {DATA_W{1'b0}};
      alu_ctrl = ALU_ADD;
      alu_flag = 1'b0;
      dest     = DEST_NONE;
      if (exec) begin
         case (op)
            OP_ADD16, OP_SUB16: begin
               // SUB reuses the ADD schedule with flag=1, except the borrow compare order.
               case (step)
                  2'd0: begin
                     alu_a = a_lo_s;  alu_b = b_lo_s;
                     alu_flag = (op == OP_SUB16);  dest = DEST_R_LO;
                  end
                  2'd1: begin
                     alu_ctrl = ALU_SLTU;  dest = DEST_CARRY;
                     if (op == OP_SUB16) begin
                        alu_a = a_lo_s;  alu_b = b_lo_s;
                     end else begin
                        alu_a = r_lo;    alu_b = a_lo_s;
                     end
                  end
                  2'd2: begin
                     alu_a = a_hi_s;  alu_b = b_hi_s;
                     alu_flag = (op == OP_SUB16);  dest = DEST_T;
                  end
                  2'd3: begin
                     alu_a = t;  alu_b = carry_s;
                     alu_flag = (op == OP_SUB16);  dest = DEST_R_HI;
                  end
                  default: dest = DEST_NONE;
               endcase
            end
            OP_NAND16, OP_NOR16: begin
               alu_ctrl = ALU_LOGIC;
               alu_flag = (op == OP_NAND16);
               if (step == 2'd0) begin
                  alu_a = a_lo_s;  alu_b = b_lo_s;  dest = DEST_R_LO;
               end else begin
                  alu_a = a_hi_s;  alu_b = b_hi_s;  dest = DEST_R_HI;
               end
            end
            OP_SLTU16: begin
               alu_ctrl = ALU_SLTU;
               case (step)
                  2'd0: begin alu_a = a_hi_s; alu_b = b_hi_s; dest = DEST_LT; end
                  2'd1: begin alu_a = b_hi_s; alu_b = a_hi_s; dest = DEST_GT; end
                  2'd2: begin alu_a = a_lo_s; alu_b = b_lo_s; dest = DEST_LL; end
                  default: dest = DEST_NONE;
               endcase
            end
            default: dest = DEST_NONE;
         endcase
      end else begin
         dest = DEST_NONE;
      end
   end

endmodule

// File: rtl/alu_seq16.sv
// 16-bit operation sequencer over the shared 8-bit ALU: accepts one request,
// issues one byte-wide micro-op per cycle and returns a registered result.
module alu_seq16
   import octa_alu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [2:0]          req_op,
   input  logic [2*DATA_W-1:0] req_a,
   input  logic [2*DATA_W-1:0] req_b,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [2*DATA_W-1:0] rsp_data,
   output logic                rsp_err,
   output logic [DATA_W-1:0]   alu_a,
   output logic [DATA_W-1:0]   alu_b,
   output logic [2:0]          alu_ctrl,
   output logic                alu_flag,
   input  logic [DATA_W-1:0]   alu_out,
   output logic                busy
);

   seq_state_e          state_r;
   logic [1:0]          step_r;
   logic [2:0]          op_r;
   logic [2*DATA_W-1:0] a_r, b_r;
   logic [DATA_W-1:0]   r_lo_r, t_r;
   logic                carry_r, lt_r, gt_r;
   logic                req_ready_r, rsp_valid_r, rsp_err_r, busy_r;
   logic [2*DATA_W-1:0] rsp_data_r;
   dest_e               dest_s;
   logic [2*DATA_W-1:0] result_s;

   alu_seq16_ucode #(.DATA_W(DATA_W)) u_ucode (
      .exec     (state_r == ST_EXEC),
      .op       (op_r),
      .step     (step_r),
      .a        (a_r),
      .b        (b_r),
      .r_lo     (r_lo_r),
      .t        (t_r),
      .carry    (carry_r),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_ctrl (alu_ctrl),
      .alu_flag (alu_flag),
      .dest     (dest_s)
   );

   // Final result: the last step's ALU output joins the saved low byte, or closes the compare.
   always_comb begin
      result_s = {(2*DATA_W){1'b0}};
      if (dest_s == DEST_LL) begin
         result_s = {{(2*DATA_W-1){1'b0}}, lt_r | (~gt_r & alu_out[0])};
      end else begin
         result_s = {alu_out, r_lo_r};
      end
   end

   // Sequencer FSM, step counter, operand/temporary registers and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         step_r      <= 2'd0;
         op_r        <= 3'b000;
         a_r         <= {(2*DATA_W){1'b0}};
         b_r         <= {(2*DATA_W){1'b0}};
         r_lo_r      <= {DATA_W{1'b0}};
         t_r         <= {DATA_W{1'b0}};
         carry_r     <= 1'b0;
         lt_r        <= 1'b0;
         gt_r        <= 1'b0;
         req_ready_r <= 1'b1;
         rsp_valid_r <= 1'b0;
         rsp_err_r   <= 1'b0;
         rsp_data_r  <= {(2*DATA_W){1'b0}};
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (req_valid) begin
                  op_r        <= req_op;
                  a_r         <= req_a;
                  b_r         <= req_b;
                  step_r      <= 2'd0;
                  req_ready_r <= 1'b0;
                  busy_r      <= 1'b1;
                  if (op_legal(req_op)) begin
                     state_r <= ST_EXEC;
                  end else begin
                     // Illegal ops bypass the ALU entirely.
                     state_r     <= ST_DONE;
                     rsp_valid_r <= 1'b1;
                     rsp_err_r   <= 1'b1;
                     rsp_data_r  <= {(2*DATA_W){1'b0}};
                  end
               end
            end
            ST_EXEC: begin
               case (dest_s)
                  DEST_R_LO:  r_lo_r  <= alu_out;
                  DEST_CARRY: carry_r <= alu_out[0];
                  DEST_T:     t_r     <= alu_out;
                  DEST_LT:    lt_r    <= alu_out[0];
                  DEST_GT:    gt_r    <= alu_out[0];
                  default:    ;
               endcase
               if (step_r == op_last_step(op_r)) begin
                  state_r     <= ST_DONE;
                  rsp_valid_r <= 1'b1;
                  rsp_err_r   <= 1'b0;
                  rsp_data_r  <= result_s;
               end else begin
                  step_r <= step_r + 2'd1;
               end
            end
            ST_DONE: begin
               if (rsp_ready) begin
                  state_r     <= ST_IDLE;
                  rsp_valid_r <= 1'b0;
                  req_ready_r <= 1'b1;
                  busy_r      <= 1'b0;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               rsp_valid_r <= 1'b0;
               req_ready_r <= 1'b1;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready = req_ready_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_err   = rsp_err_r;
   assign rsp_data  = rsp_data_r;
   assign busy      = busy_r;

endmodule
